// File: rtl/matmul_sequencer.sv
// ---------------------------------------------------------------------------
// matmul_sequencer
//   Control FSM for a square-matrix multiplier datapath. On start it computes
//   C = A x B for N x N matrices, one C element at a time: it walks k over the
//   operand memories, steers an external MAC (clear/enable/last), waits for
//   the dot product, writes it to C memory and accumulates a 32-bit running
//   sum of all C elements. It also counts the cycles the run consumes.
//
// Ports
//   CLK, RSTN        clock (rising edge) / asynchronous active-low reset
//   start            single-cycle request; honoured only in IDLE or DONE
//   rd_en            operand read strobe for A and B memories
//   a_addr, b_addr   operand addresses i*N+k and k*N+j (held outside FETCH)
//   mac_clr/en/last  MAC controls, rd_en-aligned qualifiers delayed READ_LAT
//   acc_in           dot product from the MAC
//   c_wr_en          C memory write strobe
//   c_addr, c_data   C address i*N+j and data (held outside WRITE)
//   result           sum of all C elements of this run, modulo 2^32
//   clkcount         busy cycles of this run, saturating at 1023
//   busy             high in FETCH, WAIT and WRITE
//   done_L           active-low completion flag (low in DONE)
//   dbg_state        current FSM state encoding
//
// Handshake: there is no back-pressure anywhere. start is a one-cycle pulse
// sampled only in IDLE/DONE (ignored while busy). rd_en, mac_* and c_wr_en
// are one-cycle qualifiers: the matching address/data is valid in exactly the
// cycle the strobe is high, and the consumer must accept it in that cycle.
// ---------------------------------------------------------------------------
module matmul_sequencer #(
  parameter int N        = 4,
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int READ_LAT = 1,
  parameter int MAC_LAT  = 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          start,
  output logic          rd_en,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          mac_last,
  input  logic [DW-1:0] acc_in,
  output logic          c_wr_en,
  output logic [AW-1:0] c_addr,
  output logic [DW-1:0] c_data,
  output logic [31:0]   result,
  output logic [9:0]    clkcount,
  output logic          busy,
  output logic          done_L,
  output logic [2:0]    dbg_state
);

  localparam int CW       = $clog2(N);
  localparam int WAIT_LEN = READ_LAT + MAC_LAT;
  localparam int WW       = $clog2(WAIT_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]       i_q, i_d, j_q, j_d, k_q, k_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [AW-1:0]       a_addr_q, a_addr_d, b_addr_q, b_addr_d;
  logic [AW-1:0]       c_addr_q, c_addr_d;
  logic [DW-1:0]       c_data_q, c_data_d;
  logic [31:0]         result_q, result_d;
  logic [9:0]          clkcount_q, clkcount_d;
  logic [READ_LAT-1:0] en_dl_q, en_dl_d, clr_dl_q, clr_dl_d, last_dl_q, last_dl_d;

  logic k_first, k_final, j_final, i_final;

  assign k_first = (k_q == '0);
  assign k_final = (k_q == CW'(N - 1));
  assign j_final = (j_q == CW'(N - 1));
  assign i_final = (i_q == CW'(N - 1));

  // Output decode. Addresses and C data are live in their own state and fall
  // back to the last registered value elsewhere, so they hold between uses.
  always_comb begin
    rd_en     = (state_q == S_FETCH);
    c_wr_en   = (state_q == S_WRITE);
    busy      = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_WRITE);
    done_L    = (state_q != S_DONE);
    a_addr    = rd_en ? (AW'(i_q) * AW'(N) + AW'(k_q)) : a_addr_q;
    b_addr    = rd_en ? (AW'(k_q) * AW'(N) + AW'(j_q)) : b_addr_q;
    c_addr    = c_wr_en ? (AW'(i_q) * AW'(N) + AW'(j_q)) : c_addr_q;
    c_data    = c_wr_en ? acc_in : c_data_q;
    mac_en    = en_dl_q[READ_LAT-1];
    mac_clr   = clr_dl_q[READ_LAT-1];
    mac_last  = last_dl_q[READ_LAT-1];
    result    = result_q;
    clkcount  = clkcount_q;
    dbg_state = state_q;
  end

  // Delay line: the MAC controls track the read strobe so that each enable
  // lines up with the operand data returned READ_LAT cycles later.
  always_comb begin
    en_dl_d      = en_dl_q;
    clr_dl_d     = clr_dl_q;
    last_dl_d    = last_dl_q;
    en_dl_d[0]   = rd_en;
    clr_dl_d[0]  = rd_en && k_first;
    last_dl_d[0] = rd_en && k_final;
    for (int n = 1; n < READ_LAT; n++) begin
      en_dl_d[n]   = en_dl_q[n-1];
      clr_dl_d[n]  = clr_dl_q[n-1];
      last_dl_d[n] = last_dl_q[n-1];
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    wait_d     = wait_q;
    a_addr_d   = a_addr;
    b_addr_d   = b_addr;
    c_addr_d   = c_addr;
    c_data_d   = c_data;
    result_d   = result_q;
    clkcount_d = clkcount_q;

    if (busy && (clkcount_q != 10'd1023)) begin
      clkcount_d = clkcount_q + 10'd1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_FETCH;
          i_d        = '0;
          j_d        = '0;
          k_d        = '0;
          wait_d     = '0;
          result_d   = '0;
          clkcount_d = '0;
        end
      end
      S_FETCH: begin
        if (k_final) begin
          k_d     = '0;
          wait_d  = '0;
          state_d = S_WAIT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_WAIT: begin
        // Covers the operand read latency plus the MAC latency after the
        // last enable, so acc_in is settled when WRITE samples it.
        if (wait_q == WW'(WAIT_LEN - 1)) begin
          state_d = S_WRITE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WRITE: begin
        result_d = result_q + 32'(acc_in);
        if (j_final) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
        k_d = '0;
        if (i_final && j_final) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      wait_q     <= '0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      c_addr_q   <= '0;
      c_data_q   <= '0;
      result_q   <= '0;
      clkcount_q <= '0;
      en_dl_q    <= '0;
      clr_dl_q   <= '0;
      last_dl_q  <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      wait_q     <= wait_d;
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
      c_addr_q   <= c_addr_d;
      c_data_q   <= c_data_d;
      result_q   <= result_d;
      clkcount_q <= clkcount_d;
      en_dl_q    <= en_dl_d;
      clr_dl_q   <= clr_dl_d;
      last_dl_q  <= last_dl_d;
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_matmul_sequencer
//   Two sequencer instances with bench-side operand memories and MAC models:
//   dut1 (N=4, READ_LAT=1, MAC_LAT=1) and dut2 (N=16, READ_LAT=2, MAC_LAT=1).
//   Expected C writes and end-of-run result/clkcount are pushed into queues
//   when a run is launched; monitors pop and compare on c_wr_en and on the
//   falling edge of done_L.
// ---------------------------------------------------------------------------
module tb_matmul_sequencer;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RSTN  = 1'b0;
  logic RSTN2 = 1'b0;

  // ---------------- dut1 signals ----------------
  logic        start1 = 1'b0;
  logic        rd_en1, mac_clr1, mac_en1, mac_last1, c_wr_en1, busy1, done_L1;
  logic [9:0]  a_addr1, b_addr1, c_addr1, clkcount1;
  logic [31:0] acc1 = '0;
  logic [31:0] c_data1, result1;
  logic [2:0]  dbg_state1;

  // ---------------- dut2 signals ----------------
  logic        start2 = 1'b0;
  logic        rd_en2, mac_clr2, mac_en2, mac_last2, c_wr_en2, busy2, done_L2;
  logic [9:0]  a_addr2, b_addr2, c_addr2, clkcount2;
  logic [31:0] acc2 = '0;
  logic [31:0] c_data2, result2;
  logic [2:0]  dbg_state2;

  matmul_sequencer #(.N(4), .AW(10), .DW(32), .READ_LAT(1), .MAC_LAT(1)) dut1 (
    .CLK(CLK), .RSTN(RSTN), .start(start1),
    .rd_en(rd_en1), .a_addr(a_addr1), .b_addr(b_addr1),
    .mac_clr(mac_clr1), .mac_en(mac_en1), .mac_last(mac_last1),
    .acc_in(acc1), .c_wr_en(c_wr_en1), .c_addr(c_addr1), .c_data(c_data1),
    .result(result1), .clkcount(clkcount1), .busy(busy1), .done_L(done_L1),
    .dbg_state(dbg_state1)
  );

  matmul_sequencer #(.N(16), .AW(10), .DW(32), .READ_LAT(2), .MAC_LAT(1)) dut2 (
    .CLK(CLK), .RSTN(RSTN2), .start(start2),
    .rd_en(rd_en2), .a_addr(a_addr2), .b_addr(b_addr2),
    .mac_clr(mac_clr2), .mac_en(mac_en2), .mac_last(mac_last2),
    .acc_in(acc2), .c_wr_en(c_wr_en2), .c_addr(c_addr2), .c_data(c_data2),
    .result(result2), .clkcount(clkcount2), .busy(busy2), .done_L(done_L2),
    .dbg_state(dbg_state2)
  );

  // ---------------- memory and MAC models ----------------
  logic [31:0] a_mem1 [0:1023];
  logic [31:0] b_mem1 [0:1023];
  logic [31:0] a_mem2 [0:1023];
  logic [31:0] b_mem2 [0:1023];
  logic [31:0] a_rd1 = '0, b_rd1 = '0;
  logic [31:0] a_p2 = '0, b_p2 = '0, a_rd2 = '0, b_rd2 = '0;

  always @(posedge CLK) begin
    a_rd1 <= a_mem1[a_addr1];
    b_rd1 <= b_mem1[b_addr1];
    if (mac_en1) acc1 <= (mac_clr1 ? 32'd0 : acc1) + a_rd1 * b_rd1;
  end

  always @(posedge CLK) begin
    a_p2  <= a_mem2[a_addr2];
    b_p2  <= b_mem2[b_addr2];
    a_rd2 <= a_p2;
    b_rd2 <= b_p2;
    if (mac_en2) acc2 <= (mac_clr2 ? 32'd0 : acc2) + a_rd2 * b_rd2;
  end

  // ---------------- scoreboard ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [41:0] exp_wr1_q[$];   // {c_addr, c_data}
  logic [41:0] exp_end1_q[$];  // {result, clkcount}
  logic [41:0] exp_wr2_q[$];
  logic [41:0] exp_end2_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  logic [41:0] e1, e2;
  logic done_prev1 = 1'b1;
  logic done_prev2 = 1'b1;

  always @(negedge CLK) begin
    if (c_wr_en1) begin
      if (exp_wr1_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL dut1_unexpected_write: got addr %0d data 0x%0h expected no write",
                 c_addr1, c_data1);
      end else begin
        e1 = exp_wr1_q.pop_front();
        chk("dut1_c_addr", 64'(c_addr1), 64'(e1[41:32]));
        chk("dut1_c_data", 64'(c_data1), 64'(e1[31:0]));
      end
    end
    if (done_prev1 && !done_L1) begin
      if (exp_end1_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL dut1_unexpected_done: got done_L fall expected none");
      end else begin
        e1 = exp_end1_q.pop_front();
        chk("dut1_result", 64'(result1), 64'(e1[41:10]));
        chk("dut1_clkcount", 64'(clkcount1), 64'(e1[9:0]));
      end
    end
    done_prev1 = done_L1;
  end

  always @(negedge CLK) begin
    if (c_wr_en2) begin
      if (exp_wr2_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL dut2_unexpected_write: got addr %0d data 0x%0h expected no write",
                 c_addr2, c_data2);
      end else begin
        e2 = exp_wr2_q.pop_front();
        chk("dut2_c_addr", 64'(c_addr2), 64'(e2[41:32]));
        chk("dut2_c_data", 64'(c_data2), 64'(e2[31:0]));
      end
    end
    if (done_prev2 && !done_L2) begin
      if (exp_end2_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL dut2_unexpected_done: got done_L fall expected none");
      end else begin
        e2 = exp_end2_q.pop_front();
        chk("dut2_result", 64'(result2), 64'(e2[41:10]));
        chk("dut2_clkcount", 64'(clkcount2), 64'(e2[9:0]));
      end
    end
    done_prev2 = done_L2;
  end

  // MAC control alignment on dut1: each control must equal the bench's own
  // view of the read stream (any/first/last rd_en of an element) one cycle
  // earlier.
  bit   chk_mac = 1'b0;
  logic rd_d1 = 1'b0, first_d1 = 1'b0, last_d1 = 1'b0;
  int   rd_cnt = 0;

  always @(negedge CLK) begin
    if (!chk_mac) begin
      rd_d1 = 1'b0; first_d1 = 1'b0; last_d1 = 1'b0; rd_cnt = 0;
    end else begin
      chk("mac_en_align", 64'(mac_en1), 64'(rd_d1));
      chk("mac_clr_align", 64'(mac_clr1), 64'(first_d1));
      chk("mac_last_align", 64'(mac_last1), 64'(last_d1));
      rd_d1    = rd_en1;
      first_d1 = rd_en1 && (rd_cnt == 0);
      last_d1  = rd_en1 && (rd_cnt == 3);
      if (rd_en1) rd_cnt = (rd_cnt + 1) % 4;
    end
  end

  // ---------------- driver tasks ----------------
  // mode 0: A = identity, B[r][c] = r*4+c
  // mode 1: A = B = all ones
  // mode 2: A = B = all 0xFFFF
  task automatic load_mems1(input int mode);
    for (int a = 0; a < 16; a++) begin
      case (mode)
        0: begin a_mem1[a] = ((a / 4) == (a % 4)) ? 32'd1 : 32'd0; b_mem1[a] = 32'(a); end
        1: begin a_mem1[a] = 32'd1; b_mem1[a] = 32'd1; end
        default: begin a_mem1[a] = 32'hFFFF; b_mem1[a] = 32'hFFFF; end
      endcase
    end
  endtask

  // Hand-computed expectations:
  //   mode 0: C = B, so c_data = addr, sum 0..15 = 0x78
  //   mode 1: each element 4 x 1 = 4, sum 16 x 4 = 0x40
  //   mode 2: 0xFFFF^2 = 0xFFFE0001; x4 = 0x3_FFF8_0004 -> 0xFFF80004;
  //           x16 = 0xF_FF80_0040 -> 0xFF800040
  task automatic push_run1(input int mode);
    logic [31:0] d;
    logic [31:0] r;
    r = (mode == 0) ? 32'h78 : (mode == 1) ? 32'h40 : 32'hFF80_0040;
    for (int a = 0; a < 16; a++) begin
      d = (mode == 0) ? 32'(a) : (mode == 1) ? 32'd4 : 32'hFFF8_0004;
      exp_wr1_q.push_back({10'(a), d});
    end
    exp_end1_q.push_back({r, 10'd112});
  endtask

  // Launches a run on dut1 and waits (bounded) for done_L. A start pulse is
  // re-issued at cycle 'glitch' of the run (-1 = never).
  task automatic run1(input int glitch, input string tag);
    int busy_cyc = 0;
    bit seen = 1'b0;
    start1 = 1'b1;
    @(negedge CLK);
    start1 = 1'b0;
    chk({tag, "_done_L_cleared"}, 64'(done_L1), 64'd1);
    chk({tag, "_result_cleared"}, 64'(result1), 64'd0);
    chk({tag, "_clkcount_cleared"}, 64'(clkcount1), 64'd0);
    for (int c = 1; c <= 400; c++) begin
      if (!done_L1) begin
        seen = 1'b1;
        break;
      end
      if (busy1) busy_cyc++;
      start1 = (c == glitch);
      @(negedge CLK);
    end
    start1 = 1'b0;
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd112);
  endtask

  task automatic run2(input string tag);
    int busy_cyc = 0;
    bit seen = 1'b0;
    start2 = 1'b1;
    @(negedge CLK);
    start2 = 1'b0;
    chk({tag, "_done_L_cleared"}, 64'(done_L2), 64'd1);
    chk({tag, "_result_cleared"}, 64'(result2), 64'd0);
    chk({tag, "_clkcount_cleared"}, 64'(clkcount2), 64'd0);
    for (int c = 1; c <= 6000; c++) begin
      if (!done_L2) begin
        seen = 1'b1;
        break;
      end
      if (busy2) busy_cyc++;
      @(negedge CLK);
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    // 256 elements x (16 + 2 + 1 + 1) cycles
    chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'd5120);
  endtask

  task automatic chk_reset_outputs1(input string tag);
    chk({tag, "_rd_en"}, 64'(rd_en1), 64'd0);
    chk({tag, "_mac_en"}, 64'(mac_en1), 64'd0);
    chk({tag, "_mac_clr"}, 64'(mac_clr1), 64'd0);
    chk({tag, "_mac_last"}, 64'(mac_last1), 64'd0);
    chk({tag, "_c_wr_en"}, 64'(c_wr_en1), 64'd0);
    chk({tag, "_a_addr"}, 64'(a_addr1), 64'd0);
    chk({tag, "_b_addr"}, 64'(b_addr1), 64'd0);
    chk({tag, "_c_addr"}, 64'(c_addr1), 64'd0);
    chk({tag, "_c_data"}, 64'(c_data1), 64'd0);
    chk({tag, "_result"}, 64'(result1), 64'd0);
    chk({tag, "_clkcount"}, 64'(clkcount1), 64'd0);
    chk({tag, "_busy"}, 64'(busy1), 64'd0);
    chk({tag, "_done_L"}, 64'(done_L1), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    for (int a = 0; a < 1024; a++) begin
      a_mem1[a] = '0; b_mem1[a] = '0; a_mem2[a] = '0; b_mem2[a] = '0;
    end
    for (int a = 0; a < 256; a++) begin
      a_mem2[a] = ((a / 16) == (a % 16)) ? 32'd1 : 32'd0;
      b_mem2[a] = 32'(a);
    end

    repeat (3) @(negedge CLK);
    chk_reset_outputs1("por");
    RSTN  = 1'b1;
    RSTN2 = 1'b1;
    @(negedge CLK);
    chk("idle_busy", 64'(busy1), 64'd0);
    chk("idle_done_L", 64'(done_L1), 64'd1);

    // identity x B
    load_mems1(0);
    push_run1(0);
    run1(-1, "t_ident");
    repeat (3) @(negedge CLK);
    chk("done_hold_done_L", 64'(done_L1), 64'd0);
    chk("done_hold_clkcount", 64'(clkcount1), 64'd112);

    // all ones, with MAC control alignment checks
    load_mems1(1);
    push_run1(1);
    chk_mac = 1'b1;
    run1(-1, "t_ones");
    @(negedge CLK);
    chk_mac = 1'b0;

    // start pulse mid-run is ignored
    load_mems1(0);
    push_run1(0);
    run1(30, "t_restart_ignored");

    // asynchronous reset in the first WAIT of a run: no write may follow
    start1 = 1'b1;
    @(negedge CLK);
    start1 = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (dbg_state1 == 3'd2) begin
        found = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    chk("abort_wait_reached", 64'(found), 64'd1);
    #2 RSTN = 1'b0;
    #1 chk_reset_outputs1("abort");
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    push_run1(0);
    run1(-1, "t_after_abort");

    // large operands, wrap-around arithmetic
    load_mems1(2);
    push_run1(2);
    run1(-1, "t_ffff");

    // dut2: clkcount saturation, then a second run from DONE
    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < 256; a++) exp_wr2_q.push_back({10'(a), 32'(a)});
      // sum 0..255 = 32640 = 0x7F80; 5120 busy cycles saturate at 1023
      exp_end2_q.push_back({32'h7F80, 10'd1023});
      run2((r == 0) ? "t_sat_run1" : "t_sat_run2");
      repeat (2) @(negedge CLK);
    end

    chk("dut1_wr_queue_drained", 64'(exp_wr1_q.size()), 64'd0);
    chk("dut1_end_queue_drained", 64'(exp_end1_q.size()), 64'd0);
    chk("dut2_wr_queue_drained", 64'(exp_wr2_q.size()), 64'd0);
    chk("dut2_end_queue_drained", 64'(exp_end2_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
